// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-count receive path: width, FSM encoding
// and the Gray-to-binary conversion used by the decoder.
package gray_pkg;

  localparam int GRAY_W = 4;
  localparam int LAP_W  = 8;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } rx_state_e;

  // MSB passes straight through; each lower bit folds in everything above it.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_sync_2ff.sv
// Two-flop synchronizer bringing the foreign-clock Gray count into the clk domain.
module gray_sync_2ff #(
  parameter int W = gray_pkg::GRAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/gray_rx_decoder.sv
// Receives a Gray counter from another clock domain, decodes it to binary and
// checks that it only ever advances by one, counting wraps and flagging faults.
module gray_rx_decoder #(
  parameter int GRAY_W = gray_pkg::GRAY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [GRAY_W-1:0] gray_in,
  input  logic              err_clr,
  output logic [GRAY_W-1:0] bin_out,
  output logic              step_valid,
  output logic              wrap,
  output logic [7:0]        lap_cnt,
  output logic              err
);

  import gray_pkg::*;

  logic [GRAY_W-1:0] sync2;

  rx_state_e         state_q;
  logic [GRAY_W-1:0] prev_q;
  logic [GRAY_W-1:0] bin_q;
  logic              step_q;
  logic              wrap_q;
  logic [7:0]        lap_q;
  logic              err_q;

  logic [GRAY_W-1:0] sampleBin_d;
  logic [GRAY_W-1:0] prevBin;
  logic [GRAY_W-1:0] expectBin;
  logic              isLegal;
  logic              isWrap;
  logic [7:0]        lap_d;

  gray_sync_2ff #(
    .W(GRAY_W)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (gray_in),
    .q_o (sync2)
  );

  // A legal sample is exactly the successor of the last accepted value.
  always_comb begin
    sampleBin_d = gray2bin(sync2);
    prevBin     = gray2bin(prev_q);
    expectBin   = prevBin + GRAY_W'(1);
    isLegal     = (sync2 != prev_q) && (sampleBin_d == expectBin);
    isWrap      = isLegal && (prevBin == '1);
    lap_d       = lap_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACQ;
      prev_q  <= '0;
      bin_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      lap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        ACQ: begin
          if (clk_en) begin
            prev_q  <= sync2;
            bin_q   <= sampleBin_d;
            state_q <= TRACK;
          end
        end
        TRACK: begin
          if (clk_en && (sync2 != prev_q)) begin
            prev_q <= sync2;
            bin_q  <= sampleBin_d;
            if (isLegal) begin
              step_q <= 1'b1;
              if (isWrap) begin
                wrap_q <= 1'b1;
                lap_q  <= lap_d;
              end
            end else begin
              state_q <= FAULT;
              err_q   <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (clk_en) begin
            prev_q <= sync2;
            bin_q  <= sampleBin_d;
          end
          // Clearing is honoured even while the checker is disabled.
          if (err_clr) begin
            state_q <= ACQ;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ACQ;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out    = bin_q;
  assign step_valid = step_q;
  assign wrap       = wrap_q;
  assign lap_cnt    = lap_q;
  assign err        = err_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed bench for gray_rx_decoder: counting, wrap/lap, enable gating,
// illegal and backward steps, fault recovery and reset mid-count.
module tb_gray_rx_decoder;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       step_valid;
  logic       wrap;
  logic [7:0] lap_cnt;
  logic       err;

  int checkCount = 0;
  int passCount  = 0;
  int stepCount  = 0;
  int wrapCount  = 0;
  int runCount   = 0;
  logic lastStep = 1'b0;
  int s0;
  int w0;

  gray_rx_decoder #(.GRAY_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .bin_out    (bin_out),
    .step_valid (step_valid),
    .wrap       (wrap),
    .lap_cnt    (lap_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are tallied one edge late, so readers at the falling edge never race them.
  always @(posedge clk) begin
    if (step_valid) stepCount++;
    if (wrap) wrapCount++;
    if (step_valid && lastStep) runCount++;
    lastStep = step_valid;
  end

  function automatic logic [3:0] toGray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] g, input int cycles);
    gray_in = g;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic runLaps(input int n);
    for (int c = 0; c < n; c++) begin
      for (int b = 1; b <= 16; b++) applyStimulus(toGray(b), 2);
    end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; gray_in = 4'b0000; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset bin_out", bin_out, 0);
    checkOutput("reset step_valid", step_valid, 0);
    checkOutput("reset wrap", wrap, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset lap_cnt", lap_cnt, 0);

    // Full count 0..15,0 with 4-cycle holds
    rst = 1'b1; clk_en = 1'b1;
    applyStimulus(4'b0000, 4);
    checkOutput("acquire bin_out", bin_out, 0);
    s0 = stepCount; w0 = wrapCount;
    for (int b = 1; b <= 16; b++) begin
      applyStimulus(toGray(b), 4);
      checkOutput($sformatf("count bin_out %0d", b), bin_out, b % 16);
    end
    applyStimulus(4'b0000, 2);
    checkOutput("count steps", stepCount - s0, 16);
    checkOutput("count wraps", wrapCount - w0, 1);
    checkOutput("count lap_cnt", lap_cnt, 1);
    checkOutput("count err", err, 0);

    // Enable gating
    applyStimulus(toGray(1), 4);
    s0 = stepCount;
    clk_en = 1'b0;
    applyStimulus(4'b0011, 4);
    checkOutput("gated bin_out", bin_out, 1);
    checkOutput("gated steps", stepCount - s0, 0);
    clk_en = 1'b1;
    @(negedge clk);
    checkOutput("ungated bin_out", bin_out, 2);
    checkOutput("ungated step_valid", step_valid, 1);
    @(negedge clk);
    checkOutput("ungated pulse width", step_valid, 0);
    repeat (2) @(negedge clk);
    checkOutput("ungated steps", stepCount - s0, 1);

    // Illegal jump 0011 -> 0101
    s0 = stepCount;
    applyStimulus(4'b0101, 2);
    checkOutput("jump err early", err, 0);
    @(negedge clk);
    checkOutput("jump err", err, 1);
    checkOutput("jump bin_out", bin_out, 6);
    checkOutput("jump step_valid", step_valid, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("clear err", err, 0);
    @(negedge clk);
    checkOutput("reacq bin_out", bin_out, 6);
    repeat (2) @(negedge clk);
    checkOutput("jump steps", stepCount - s0, 0);

    // err_clr in TRACK must not disturb tracking
    s0 = stepCount;
    err_clr = 1'b1;
    applyStimulus(toGray(7), 1);
    err_clr = 1'b0;
    applyStimulus(toGray(7), 3);
    checkOutput("track clr err", err, 0);
    checkOutput("track clr bin_out", bin_out, 7);
    checkOutput("track clr steps", stepCount - s0, 1);

    // Backward step 0110 -> 0010
    applyStimulus(4'b0110, 4);
    checkOutput("skip err", err, 1);
    checkOutput("skip bin_out", bin_out, 4);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("reacq4 err", err, 0);
    checkOutput("reacq4 bin_out", bin_out, 4);
    s0 = stepCount; w0 = wrapCount;
    applyStimulus(4'b0010, 4);
    checkOutput("back err", err, 1);
    checkOutput("back bin_out", bin_out, 3);
    checkOutput("back steps", stepCount - s0, 0);

    // FAULT keeps decoding without pulses or lap changes
    applyStimulus(toGray(4), 4);
    checkOutput("fault bin_out", bin_out, 4);
    applyStimulus(toGray(15), 4);
    applyStimulus(4'b0000, 4);
    checkOutput("fault wrap bin_out", bin_out, 0);
    checkOutput("fault steps", stepCount - s0, 0);
    checkOutput("fault wraps", wrapCount - w0, 0);
    checkOutput("fault lap_cnt", lap_cnt, 1);
    checkOutput("fault err", err, 1);

    // 256 laps from a fresh reset
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b0000, 4);
    checkOutput("laps start lap_cnt", lap_cnt, 0);
    s0 = stepCount; w0 = wrapCount;
    runLaps(255);
    applyStimulus(4'b0000, 2);
    checkOutput("laps 255 lap_cnt", lap_cnt, 255);
    runLaps(1);
    applyStimulus(4'b0000, 2);
    checkOutput("laps 256 lap_cnt", lap_cnt, 0);
    checkOutput("laps wraps", wrapCount - w0, 256);
    checkOutput("laps steps", stepCount - s0, 4096);
    checkOutput("laps err", err, 0);
    checkOutput("pulse runs", runCount, 0);

    // Reset mid-count at bin 9, lap 3
    runLaps(3);
    for (int b = 1; b <= 9; b++) applyStimulus(toGray(b), 2);
    applyStimulus(toGray(9), 2);
    checkOutput("pre-reset bin_out", bin_out, 9);
    checkOutput("pre-reset lap_cnt", lap_cnt, 3);
    rst = 1'b0;
    #1;
    checkOutput("mid reset bin_out", bin_out, 0);
    checkOutput("mid reset lap_cnt", lap_cnt, 0);
    checkOutput("mid reset err", err, 0);
    checkOutput("mid reset step_valid", step_valid, 0);
    checkOutput("mid reset wrap", wrap, 0);
    gray_in = 4'b1101;
    clk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    s0 = stepCount;
    clk_en = 1'b1;
    @(negedge clk);
    checkOutput("post reset bin_out", bin_out, 9);
    checkOutput("post reset err", err, 0);
    checkOutput("post reset step_valid", step_valid, 0);
    repeat (2) @(negedge clk);
    checkOutput("post reset steps", stepCount - s0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/gray_rx_decoder.md
GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

Interface
REQ-001 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port clk_en  input  1  checker-stage enable; synchronizer runs regardless.
REQ-004 SHALL have port gray_in  input  4  Gray count from the 4-bit Gray counter, asynchronous to clk.
REQ-005 SHALL have port err_clr  input  1  clears FAULT, forcing reacquisition.
REQ-006 SHALL have port bin_out  output  4  binary value of the last accepted Gray sample.
REQ-007 SHALL have port step_valid  output  1  one-cycle pulse on a legal +1 step.
REQ-008 SHALL have port wrap  output  1  one-cycle pulse on a legal 15->0 step (Gray 1000->0000).
REQ-009 SHALL have port lap_cnt  output  8  count of legal wraps, modulo 256.
REQ-010 SHALL have port err  output  1  high while in FAULT.
REQ-011 SHALL have parameter GRAY_W, default 4, meaning Gray/binary width; only 4 is supported.

Function
REQ-012 SHALL pass gray_in through a 2-flop synchronizer (sync1, sync2) every clk edge.
REQ-013 SHALL hold a register prev (last accepted Gray value) updated only on clk_en edges.
REQ-014 SHALL decode Gray to binary as b[3]=g[3], b[i]=b[i+1] XOR g[i].
REQ-015 SHALL use FSM states ACQ, TRACK, FAULT.
REQ-016 SHALL, in ACQ with clk_en high, load prev<=sync2 and bin_out<=decode(sync2), raise no pulse, and go to TRACK.
REQ-017 SHALL, in TRACK with clk_en high and sync2==prev, hold all registers and raise no pulse.
REQ-018 SHALL, in TRACK, treat sync2 as legal when decode(sync2)==decode(prev)+1 mod 16; it SHALL update prev/bin_out and pulse step_valid.
REQ-019 SHALL, on a legal step where decode(prev)==15, also pulse wrap and increment lap_cnt (255->0).
REQ-020 SHALL, in TRACK, treat any other change (backward step or >1 bit changed) as illegal; it SHALL update prev/bin_out, raise no pulse, and go to FAULT.
REQ-021 SHALL, in FAULT, keep bin_out tracking sync2 on clk_en edges with no pulses and no lap_cnt change.
REQ-022 SHALL, in FAULT with err_clr high, go to ACQ on that edge regardless of clk_en; err_clr SHALL be ignored in ACQ and TRACK.
REQ-023 SHALL, with clk_en low, hold FSM (except REQ-022), prev, bin_out and lap_cnt, and force step_valid and wrap to 0.
REQ-024 SHALL have latency: gray_in stable before edge k is reflected on bin_out/step_valid after edge k+2, given clk_en high at k+2.
REQ-025 SHALL register step_valid and wrap, and SHALL never assert them for more than one cycle per accepted step.

Reset
REQ-026 SHALL, while rst is low, asynchronously set sync1, sync2 and prev to 0000, bin_out to 0, step_valid, wrap and err to 0, lap_cnt to 0, and the FSM to ACQ.
REQ-027 SHALL, on reset asserted mid-operation, abandon any in-flight sample; the first enabled edge after release SHALL reacquire per REQ-016.

Structure
REQ-028 SHALL place the FSM state encoding, the GRAY_W constant and the gray-to-binary function in the shared package gray_pkg.
REQ-029 SHALL instantiate the synchronizer as sub-module gray_sync_2ff (4-bit, asynchronous active-low reset).
REQ-030 SHALL keep all other logic in gray_rx_decoder.

Verification
REQ-031 Scenario, full count: drive gray_in through 0000,0001,0011,...,1000,0000, each held 4 cycles with clk_en=1. Required response: bin_out 0..15,0; 16 step_valid pulses; 1 wrap; lap_cnt=1; err=0.
REQ-032 Scenario, illegal jump: in TRACK at 0011, drive gray_in=0101. Required response: err=1 after 3 edges, bin_out=6, no step_valid. Then err_clr for 1 cycle gives err=0 and reacquisition with no pulse.
REQ-033 Scenario, backward step: from 0110 (bin 4), drive 0010 (bin 3). Required response: FAULT, bin_out=3, no pulse.
REQ-034 Scenario, enable gating: clk_en=0 while gray_in steps 0001->0011. Required response: bin_out holds 1, no pulse. When clk_en returns to 1: bin_out=2 and a single step_valid pulse.
REQ-035 Scenario, lap wrap: 256 full cycles. Required response: lap_cnt returns to 0 and wrap count=256.
REQ-036 Scenario, reset mid-count: assert rst at bin_out=9, lap_cnt=3. Required response: all outputs 0 immediately; after release with gray_in=1101, bin_out=9 with no pulse.
